vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
// Time-slot arbiter sharing one single-port video RAM between the scan-out tile fetch and
// the CPU. Replaces the fixed-select address buffers (select tied to video) with a real
// scheduler: video owns one fetch slot per 8-pixel character, CPU gets a window slot.
// Sits between the H/V timing chain, the CPU bus interface and the playfield RAM.
// PARAMETERS
// ADDR_W     10  RAM address width (1K x 8 playfield)
// DATA_W     8   RAM data width
// VID_SLOT   0   hcnt_lo value on whose pix_ce the tile fetch is requested
// CPU_FIRST  4   first hcnt_lo value in which a CPU access may start
// CPU_LAST   6   last hcnt_lo value in which a CPU access may start
// PORTS
// clk        in   1       system clock (all state on rising edge)
// nRESET     in   1       asynchronous active-low reset
// pix_ce     in   1       pixel clock enable, 1 clk wide, spacing >= 2 clk
// hcnt_lo    in   3       {H4,H2,H1} pixel-in-character count
// vblank     in   1       vertical blank, 1 = no tile fetches
// vid_addr   in   ADDR_W  tile address from scan counters (V128..V8,H128..H8)
// vid_data   out  DATA_W  fetched tile code, held until next fetch
// vid_valid  out  1       1-clk pulse: vid_data updated
// vid_late   out  1       sticky: a fetch request found the previous one still pending
// cpu_req    in   1       CPU access request, held until cpu_ack
// cpu_we     in   1       1 = write, 0 = read (stable while cpu_req)
// cpu_addr   in   ADDR_W  CPU address
// cpu_wdata  in   DATA_W  CPU write data
// cpu_rdata  out  DATA_W  read data, valid with cpu_ack, held afterwards
// cpu_ack    out  1       1-clk pulse: access complete
// cpu_wait   out  1       cpu_req & ~cpu_ack (combinational, drives CPU WAIT)
// ram_addr   out  ADDR_W  RAM address (registered)
// ram_we     out  1       RAM write enable (registered)
// ram_wdata  out  DATA_W  RAM write data (registered)
// ram_rdata  in   DATA_W  RAM read data, synchronous, valid 1 clk after ram_addr
// BEHAVIOUR
// - Reset (async): state IDLE, all outputs 0, vid_pend=0, cpu_armed=1. ram_we drops at once.
// - States: IDLE, VID_A, VID_D, CPU_A, CPU_D. VID_A/CPU_A drive ram_addr; *_D capture ram_rdata.
// - Fetch request: pix_ce & hcnt_lo==VID_SLOT & ~vblank sets vid_pend, latches vid_addr.
//   If vid_pend already 1 at that point: vid_late<=1 (cleared only by reset).
// - IDLE priority: vid_pend first -> VID_A; else CPU start if cpu_req & cpu_armed & in window.
// - Window: hcnt_lo in [CPU_FIRST..CPU_LAST]. Video request never aborts a CPU access;
//   it waits in vid_pend (max 2 clk).
// - VID_A: ram_addr=latched vid_addr, ram_we=0 -> VID_D: vid_data<=ram_rdata, vid_pend<=0
//   -> IDLE with vid_valid=1 next clk. Request-to-vid_valid = 3 clk when IDLE.
// - CPU_A: ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata (one clk only)
//   -> CPU_D: ram_we=0, cpu_rdata<=ram_rdata (reads only; writes leave it unchanged)
//   -> IDLE with cpu_ack=1 next clk; cpu_armed<=0.
// - cpu_armed re-sets only when cpu_req sampled 0: a held req never causes a 2nd access.
// - cpu_req dropped mid-access: access completes, ack still pulses.
// - Simultaneous fetch request and CPU start in IDLE: video wins; CPU retries next IDLE.
// - Address wrap: none; addresses pass through unmodified at ADDR_W bits.
// CONFIGURATION
// VRAM_VBLANK_OPEN_EN defined: while vblank=1 the CPU window is every hcnt_lo value,
//   so CPU accesses back-to-back (one per 4 clk incl. re-arm).
// Not defined: window always CPU_FIRST..CPU_LAST, vblank only suppresses fetches.
// TESTING
// 1 Reset mid CPU write (assert nRESET=0 in CPU_A) -> ram_we=0 same clk, all outputs 0.
// 2 vblank=0, hcnt_lo=0 pix_ce, vid_addr=0x155, RAM[0x155]=0xA7 -> vid_valid 3 clk later,
//   vid_data=0xA7; no CPU activity.
// 3 cpu_req write 0x3C to 0x012 at hcnt_lo=2 -> no start until hcnt_lo=4; RAM[0x012]=0x3C;
//   cpu_ack single pulse; cpu_wait high from req until ack.
// 4 CPU read in CPU_A when fetch request arrives -> CPU completes, fetch issues in the
//   next IDLE, vid_valid within 5 clk of request, vid_late stays 0.
// 5 Hold cpu_req high 20 clk after ack -> exactly one RAM write; drop and re-raise -> second.
// 6 Force two fetch requests with first unserved (CPU held busy by stub) -> vid_late=1
//   sticky; with VRAM_VBLANK_OPEN_EN and vblank=1, CPU read at hcnt_lo=0 starts at once.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Signal bundle between the VRAM arbiter, the H/V timing chain, the CPU bus and the playfield RAM.
// slave = arbiter side, master = surrounding system (timing, CPU, RAM).
interface vram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  // timing chain
  logic              pix_ce;
  logic [2:0]        hcnt_lo;
  logic              vblank;
  // video fetch port
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              vid_late;
  // CPU port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_wait;
  // RAM port
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  pix_ce, hcnt_lo, vblank, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ram_rdata,
    output vid_data, vid_valid, vid_late,
    output cpu_rdata, cpu_ack, cpu_wait,
    output ram_addr, ram_we, ram_wdata
  );

  modport master (
    output pix_ce, hcnt_lo, vblank, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ram_rdata,
    input  vid_data, vid_valid, vid_late,
    input  cpu_rdata, cpu_ack, cpu_wait,
    input  ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Time-slot arbiter sharing one single-port video RAM between the tile fetch and the CPU.
// Define VRAM_VBLANK_OPEN_EN to open the CPU window on every hcnt_lo value during vblank.
module vram_arbiter #(
  parameter int         ADDR_W    = 10,
  parameter int         DATA_W    = 8,
  parameter logic [2:0] VID_SLOT  = 3'd0,
  parameter logic [2:0] CPU_FIRST = 3'd4,
  parameter logic [2:0] CPU_LAST  = 3'd6
) (
  input  logic          clk,
  input  logic          nRESET,
  vram_arbiter_if.slave vbus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VID_A,
    S_VID_D,
    S_CPU_A,
    S_CPU_D
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              w_fetch_req;
  logic              w_in_window;
  logic              w_cpu_start;
  logic              w_cpu_go;
  logic              w_vid_done;
  logic              w_cpu_done;
  logic [ADDR_W-1:0] w_ram_addr_nxt;
  logic              w_ram_we_nxt;
  logic [DATA_W-1:0] w_ram_wdata_nxt;

  logic              r_vid_pend;
  logic [ADDR_W-1:0] r_vid_addr;
  logic              r_cpu_armed;
  logic              r_cpu_we_lat;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_vid_data;
  logic              r_vid_valid;
  logic              r_vid_late;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_ack;

  assign w_fetch_req = vbus.pix_ce && (vbus.hcnt_lo == VID_SLOT) && !vbus.vblank;

`ifdef VRAM_VBLANK_OPEN_EN
  assign w_in_window = vbus.vblank ||
                       ((vbus.hcnt_lo >= CPU_FIRST) && (vbus.hcnt_lo <= CPU_LAST));
`else
  assign w_in_window = (vbus.hcnt_lo >= CPU_FIRST) && (vbus.hcnt_lo <= CPU_LAST);
`endif

  // A fetch request on this very edge beats a CPU start; the CPU retries from the next IDLE.
  assign w_cpu_start = vbus.cpu_req && r_cpu_armed && w_in_window && !w_fetch_req;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_state_nxt     = r_state;
    w_cpu_go        = 1'b0;
    w_vid_done      = 1'b0;
    w_cpu_done      = 1'b0;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_we_nxt    = 1'b0;
    w_ram_wdata_nxt = r_ram_wdata;
    case (r_state)
      S_IDLE: begin
        if (r_vid_pend) begin
          w_state_nxt    = S_VID_A;
          w_ram_addr_nxt = r_vid_addr;
        end else if (w_cpu_start) begin
          w_state_nxt     = S_CPU_A;
          w_cpu_go        = 1'b1;
          w_ram_addr_nxt  = vbus.cpu_addr;
          w_ram_we_nxt    = vbus.cpu_we;
          w_ram_wdata_nxt = vbus.cpu_wdata;
        end
      end
      S_VID_A: w_state_nxt = S_VID_D;
      S_VID_D: begin
        w_state_nxt = S_IDLE;
        w_vid_done  = 1'b1;
      end
      S_CPU_A: w_state_nxt = S_CPU_D;
      S_CPU_D: begin
        w_state_nxt = S_IDLE;
        w_cpu_done  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Async reset drops ram_we immediately, so a write caught mid-access never lands.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_vid_pend   <= 1'b0;
      r_vid_addr   <= '0;
      r_cpu_armed  <= 1'b1;
      r_cpu_we_lat <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_we     <= 1'b0;
      r_ram_wdata  <= '0;
      r_vid_data   <= '0;
      r_vid_valid  <= 1'b0;
      r_vid_late   <= 1'b0;
      r_cpu_rdata  <= '0;
      r_cpu_ack    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_vid_valid <= w_vid_done;
      r_cpu_ack   <= w_cpu_done;

      if (w_cpu_go)                    r_cpu_we_lat <= vbus.cpu_we;
      if (w_vid_done)                  r_vid_data   <= vbus.ram_rdata;
      if (w_cpu_done && !r_cpu_we_lat) r_cpu_rdata  <= vbus.ram_rdata;

      if (w_fetch_req) begin
        r_vid_pend <= 1'b1;
        r_vid_addr <= vbus.vid_addr;
        if (r_vid_pend) r_vid_late <= 1'b1;
      end else if (w_vid_done) begin
        r_vid_pend <= 1'b0;
      end

      // A held request must be seen low before another access may start.
      if (w_cpu_done)         r_cpu_armed <= 1'b0;
      else if (!vbus.cpu_req) r_cpu_armed <= 1'b1;
    end
  end

  assign vbus.ram_addr  = r_ram_addr;
  assign vbus.ram_we    = r_ram_we;
  assign vbus.ram_wdata = r_ram_wdata;
  assign vbus.vid_data  = r_vid_data;
  assign vbus.vid_valid = r_vid_valid;
  assign vbus.vid_late  = r_vid_late;
  assign vbus.cpu_rdata = r_cpu_rdata;
  assign vbus.cpu_ack   = r_cpu_ack;
  assign vbus.cpu_wait  = vbus.cpu_req && !r_cpu_ack;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: window vector table, hand-written corner sequences, and a randomized
// run checked against a shadow-memory model. Honours VRAM_VBLANK_OPEN_EN.
module tb_vram_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
`ifdef VRAM_VBLANK_OPEN_EN
  localparam bit OPEN = 1'b1;
`else
  localparam bit OPEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic nRESET;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .VID_SLOT(3'd0), .CPU_FIRST(3'd4), .CPU_LAST(3'd6)
  ) dut (
    .clk   (clk),
    .nRESET(nRESET),
    .vbus  (bus)
  );

  // Synchronous single-port RAM stub: read data valid one clock after the address.
  logic [DATA_W-1:0] ram     [1024];
  logic [DATA_W-1:0] ref_mem [1024];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  int cyc = 0;
  logic [2:0] edge_h;
  logic       edge_vb;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    edge_h  <= bus.hcnt_lo;
    edge_vb <= bus.vblank;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pix_ce    = 1'b0;
    bus.hcnt_lo   = 3'd0;
    bus.vblank    = 1'b0;
    bus.vid_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
  endtask

  function automatic logic [7:0] init_val(input int a);
    if (a == 'h155) return 8'hA7;
    return 8'((a * 37 + 5) & 255);
  endfunction

  typedef struct {
    logic [2:0] h;
    logic       vb;
    logic [9:0] addr;
    logic       exp_ack;
    logic [7:0] exp_rd;
  } win_vec_t;

  typedef struct {
    logic [9:0] addr;
    int         edge_no;
  } fetch_t;

  win_vec_t   vecs [12];
  fetch_t     fq [$];
  bit         cpu_done;
  bit         we_seen, got_ack, got_vid;
  int         nwr, vlat, rq;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end
    idle_inputs();
    nRESET = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_we",    bus.ram_we,    0);
    check("rst_ram_addr",  bus.ram_addr,  0);
    check("rst_vid_valid", bus.vid_valid, 0);
    check("rst_vid_late",  bus.vid_late,  0);
    check("rst_cpu_ack",   bus.cpu_ack,   0);
    check("rst_cpu_wait",  bus.cpu_wait,  0);
    #2 nRESET = 1'b1;
    step();

    // ---------------- CPU window table (reads, no fetches) ----------------
    vecs[0]  = '{3'd0, 1'b0, 10'h040, 1'b0, init_val('h040)};
    vecs[1]  = '{3'd1, 1'b0, 10'h041, 1'b0, init_val('h041)};
    vecs[2]  = '{3'd2, 1'b0, 10'h042, 1'b0, init_val('h042)};
    vecs[3]  = '{3'd3, 1'b0, 10'h043, 1'b0, init_val('h043)};
    vecs[4]  = '{3'd4, 1'b0, 10'h044, 1'b1, init_val('h044)};
    vecs[5]  = '{3'd5, 1'b0, 10'h045, 1'b1, init_val('h045)};
    vecs[6]  = '{3'd6, 1'b0, 10'h046, 1'b1, init_val('h046)};
    vecs[7]  = '{3'd7, 1'b0, 10'h047, 1'b0, init_val('h047)};
    vecs[8]  = '{3'd0, 1'b1, 10'h048, OPEN, init_val('h048)};
    vecs[9]  = '{3'd2, 1'b1, 10'h049, OPEN, init_val('h049)};
    vecs[10] = '{3'd5, 1'b1, 10'h04A, 1'b1, init_val('h04A)};
    vecs[11] = '{3'd7, 1'b1, 10'h04B, OPEN, init_val('h04B)};
    foreach (vecs[i]) begin
      bus.hcnt_lo  = vecs[i].h;
      bus.vblank   = vecs[i].vb;
      bus.cpu_addr = vecs[i].addr;
      bus.cpu_we   = 1'b0;
      bus.cpu_req  = 1'b1;
      step(); step(); step();
      check($sformatf("win%0d_ack", i),  bus.cpu_ack,  vecs[i].exp_ack);
      check($sformatf("win%0d_wait", i), bus.cpu_wait, !vecs[i].exp_ack);
      if (vecs[i].exp_ack) check($sformatf("win%0d_rdata", i), bus.cpu_rdata, vecs[i].exp_rd);
      bus.cpu_req = 1'b0;
      step(); step();
    end
    idle_inputs();
    step();

    // ---------------- tile fetch with idle arbiter: 3 clk latency ----------------
    we_seen      = 1'b0;
    bus.vid_addr = 10'h155;
    bus.pix_ce   = 1'b1;
    step();
    bus.pix_ce  = 1'b0;
    bus.hcnt_lo = 3'd1;
    we_seen |= bus.ram_we; step();
    we_seen |= bus.ram_we; step();
    check("fetch_not_early", bus.vid_valid, 0);
    we_seen |= bus.ram_we; step();
    check("fetch_valid",    bus.vid_valid, 1);
    check("fetch_data",     bus.vid_data,  8'hA7);
    check("fetch_ram_addr", bus.ram_addr,  10'h155);
    check("fetch_no_ack",   bus.cpu_ack,   0);
    step();
    check("fetch_pulse",    bus.vid_valid, 0);
    check("fetch_no_write", we_seen,       0);

    // ---------------- CPU write waits for the window ----------------
    bus.hcnt_lo   = 3'd2;
    bus.cpu_addr  = 10'h012;
    bus.cpu_wdata = 8'h3C;
    bus.cpu_we    = 1'b1;
    bus.cpu_req   = 1'b1;
    #1;
    check("wr_wait_on_req", bus.cpu_wait, 1);
    we_seen = 1'b0;
    for (int hh = 2; hh < 4; hh++) begin
      bus.hcnt_lo = 3'(hh);
      bus.pix_ce  = 1'b1;
      step(); we_seen |= bus.ram_we;
      bus.pix_ce  = 1'b0;
      step(); we_seen |= bus.ram_we;
    end
    check("wr_no_early_start", we_seen,      0);
    check("wr_wait_held",      bus.cpu_wait, 1);
    bus.hcnt_lo = 3'd4;
    step();
    check("wr_ram_we",    bus.ram_we,    1);
    check("wr_ram_addr",  bus.ram_addr,  10'h012);
    check("wr_ram_wdata", bus.ram_wdata, 8'h3C);
    step();
    check("wr_we_one_clk", bus.ram_we,  0);
    check("wr_no_ack_yet", bus.cpu_ack, 0);
    step();
    check("wr_ack",       bus.cpu_ack,  1);
    check("wr_wait_low",  bus.cpu_wait, 0);
    bus.cpu_req = 1'b0;
    step();
    check("wr_ack_pulse", bus.cpu_ack,  0);
    check("wr_ram_value", ram['h012],   8'h3C);
    ref_mem['h012] = 8'h3C;

    // ---------------- fetch request arrives during a CPU read ----------------
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 10'h012;
    bus.cpu_req  = 1'b1;
    step();
    check("mix_cpu_started", bus.ram_addr, 10'h012);
    bus.hcnt_lo  = 3'd0;
    bus.vid_addr = 10'h155;
    bus.pix_ce   = 1'b1;
    rq = cyc + 1;
    step();
    bus.pix_ce  = 1'b0;
    bus.hcnt_lo = 3'd1;
    got_ack = 1'b0;
    got_vid = 1'b0;
    vlat    = 99;
    for (int k = 0; k < 8; k++) begin
      if (bus.cpu_ack) begin
        got_ack = 1'b1;
        check("mix_cpu_rdata", bus.cpu_rdata, 8'h3C);
        bus.cpu_req = 1'b0;
      end
      if (bus.vid_valid) begin
        got_vid = 1'b1;
        vlat    = cyc - rq;
        check("mix_vid_data", bus.vid_data, 8'hA7);
      end
      step();
    end
    check("mix_cpu_done",   got_ack,               1);
    check("mix_vid_done",   got_vid,               1);
    check("mix_vid_lat_ok", (vlat >= 3 && vlat <= 5), 1);
    check("mix_no_late",    bus.vid_late,          0);

    // ---------------- held request gives one access only ----------------
    bus.hcnt_lo   = 3'd4;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 10'h020;
    bus.cpu_wdata = 8'h55;
    bus.cpu_req   = 1'b1;
    nwr = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (bus.ram_we) nwr++;
    end
    check("hold_one_write", nwr, 1);
    bus.cpu_req = 1'b0;
    step();
    bus.cpu_wdata = 8'h66;
    bus.cpu_req   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.ram_we) nwr++;
    end
    check("hold_second_write", nwr, 2);
    bus.cpu_req = 1'b0;
    step(); step();
    check("hold_ram_value", ram['h020], 8'h66);
    ref_mem['h020] = 8'h66;

    // ---------------- reset in the middle of a CPU write ----------------
    bus.cpu_addr  = 10'h030;
    bus.cpu_wdata = 8'hEE;
    bus.cpu_req   = 1'b1;
    step();
    check("rstw_in_cpu_a", bus.ram_we, 1);
    #2;
    nRESET      = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    check("rstw_ram_we",    bus.ram_we,    0);
    check("rstw_ram_addr",  bus.ram_addr,  0);
    check("rstw_ram_wdata", bus.ram_wdata, 0);
    check("rstw_vid_data",  bus.vid_data,  0);
    check("rstw_cpu_rdata", bus.cpu_rdata, 0);
    check("rstw_cpu_ack",   bus.cpu_ack,   0);
    check("rstw_cpu_wait",  bus.cpu_wait,  0);
    check("rstw_vid_valid", bus.vid_valid, 0);
    step();
    check("rstw_no_write", ram['h030], init_val('h030));
    idle_inputs();
    nRESET = 1'b1;
    step(); step();

    // ---------------- randomized traffic against shadow memory ----------------
    cpu_done = 1'b0;
    fork
      begin : rnd_timing
        int h;
        h = 0;
        while (!cpu_done && cyc < 60000) begin
          if (h == 0) begin
            bus.vid_addr = 10'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) bus.vblank = ~bus.vblank;
          end
          bus.hcnt_lo = 3'(h);
          bus.pix_ce  = 1'b1;
          if (h == 0 && !bus.vblank) fq.push_back('{bus.vid_addr, cyc + 1});
          step();
          bus.pix_ce = 1'b0;
          step();
          h = (h + 1) % 8;
        end
      end
      begin : rnd_cpu
        logic [9:0] a;
        logic [7:0] d;
        logic       w;
        bit         acked;
        for (int t = 0; t < 120; t++) begin
          repeat ($urandom_range(0, 12)) step();
          a = 10'($urandom_range(0, 63));
          d = 8'($urandom);
          w = 1'($urandom_range(0, 1));
          bus.cpu_addr  = a;
          bus.cpu_wdata = d;
          bus.cpu_we    = w;
          bus.cpu_req   = 1'b1;
          acked = 1'b0;
          for (int k = 0; k < 60 && !acked; k++) begin
            step();
            acked = bus.cpu_ack;
          end
          check("rnd_ack", acked, 1);
          if (acked) begin
            if (w) ref_mem[a] = d;
            else   check("rnd_rdata", bus.cpu_rdata, ref_mem[a]);
          end
          bus.cpu_req = 1'b0;
          step();
        end
        cpu_done = 1'b1;
      end
      begin : rnd_monitor
        int     tail;
        fetch_t f;
        tail = 0;
        for (int k = 0; k < 60000 && tail < 10; k++) begin
          if (cpu_done) tail++;
          step();
          if (bus.vid_valid) begin
            check("rnd_vid_expected", fq.size() != 0, 1);
            if (fq.size() != 0) begin
              f = fq.pop_front();
              check("rnd_vid_data", bus.vid_data, ref_mem[f.addr]);
              check("rnd_vid_lat_ok", (cyc - f.edge_no >= 3) && (cyc - f.edge_no <= 5), 1);
            end
          end
          if (bus.ram_we)
            check("rnd_we_in_window",
                  ((edge_h >= 3'd4) && (edge_h <= 3'd6)) || (OPEN && edge_vb), 1);
        end
      end
    join
    check("rnd_fetch_drained", fq.size(), 0);
    check("rnd_no_late",       bus.vid_late, 0);
    idle_inputs();
    step(); step(); step();

    // ---------------- late fetch: second request finds the first pending ----------------
    bus.hcnt_lo  = 3'd4;
    bus.cpu_addr = 10'h012;
    bus.cpu_req  = 1'b1;
    step();
    bus.hcnt_lo  = 3'd0;
    bus.vid_addr = 10'h155;
    bus.pix_ce   = 1'b1;
    step();
    bus.pix_ce = 1'b0;
    step();
    check("late_cpu_ack",   bus.cpu_ack,  1);
    check("late_not_yet",   bus.vid_late, 0);
    bus.cpu_req = 1'b0;
    bus.pix_ce  = 1'b1;
    step();
    bus.pix_ce  = 1'b0;
    bus.hcnt_lo = 3'd1;
    check("late_set",       bus.vid_late, 1);
    repeat (10) step();
    check("late_sticky",    bus.vid_late, 1);

`ifdef VRAM_VBLANK_OPEN_EN
    bus.vblank   = 1'b1;
    bus.hcnt_lo  = 3'd0;
    bus.cpu_addr = 10'h033;
    bus.cpu_we   = 1'b0;
    bus.cpu_req  = 1'b1;
    step();
    check("open_start_now", bus.ram_addr, 10'h033);
    step(); step();
    check("open_ack",   bus.cpu_ack,   1);
    check("open_rdata", bus.cpu_rdata, ref_mem['h033]);
    bus.cpu_req = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
